neuron_mac_seq: RTL and testbench
=================================

Name: neuron_mac_seq

Overview:
Sequencer that computes one neuron dot product, result = bias + sum(w[k]*x[k]) for k = 0..len-1, on a single external pipelined float multiply-accumulate unit.
- Fetches weight/input pairs from a 1-cycle-latency read port.
- Issues one MAC operation per cycle, feeding the MAC output straight back as the addend, so MAC_LAT independent partial sums are in flight.
- Reduces those partial sums serially on the same MAC and returns a single value with a done pulse.
- Sits between the layer controller (start/len/bias) and the float MAC instance plus weight/feature memories.

Parameters:
D_LEN, 32, float word width (IEEE-754 single).
ADDR_W, 8, read address width; maximum len = 2^ADDR_W.
MAC_LAT, 7, cycles from MAC operands presented to mac_out valid (multiplier plus adder pipeline). Must be >= 2.
ONE, 32'h3F80_0000, float 1.0 used as the multiplier operand during reduction.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin job; sampled only in IDLE
len  in  ADDR_W+1  number of pairs (0..2^ADDR_W), latched at start
bias  in  D_LEN  bias addend, latched at start
rd_en  out  1  read strobe to weight and feature memories
rd_addr  out  ADDR_W  pair index k
w_data  in  D_LEN  weight w[k], valid the cycle after rd_en
x_data  in  D_LEN  input x[k], valid the cycle after rd_en
mac_mul_a  out  D_LEN  MAC multiplier operand a
mac_mul_b  out  D_LEN  MAC multiplier operand b
mac_add_a  out  D_LEN  MAC addend, presented in the same cycle as the mul operands
mac_out  in  D_LEN  MAC result; value at cycle c belongs to operands issued at c-MAC_LAT
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse; result valid
result  out  D_LEN  final sum, held until next done

Behaviour:
- Reset values: rd_en=0, rd_addr=0, mac_mul_a/b/add_a=0, busy=0, done=0, result=0.
- Reset mid-job aborts to IDLE; partial-sum bank is cleared to 0.
- Definitions: T = cycle where start=1 is sampled in IDLE; s = T+2 is the first issue cycle; L = MAC_LAT; m = min(len, L).
- IDLE: wait for start. On start with len=0: result<=bias, done high at T+1, no reads or issues, busy stays 0.
- FETCH: rd_en=1 with rd_addr=k at cycle T+1+k, for k = 0..len-1.
- ISSUE: issue k occurs at cycle s+k.
  - mul_a = x_data, mul_b = w_data.
  - add_a = bias for k=0; 0 for 1<=k<L; mac_out for k>=L.
  - When not issuing, all MAC operand outputs are 0.
- CAPTURE: during cycles s+len-1+L-m+1 .. s+len-1+L, mac_out is written into bank[j mod L], where j is the issue index that produced it. m lanes are filled; unused lanes stay 0.
- REDUCE: skipped when m=1. Otherwise step r = 1..m-1 issues at cycle s+len+r*L:
  - mul_a = bank[r], mul_b = ONE.
  - add_a = bank[0] for r=1, otherwise mac_out.
- Final value cycle c_F:
  - c_F = s+len-1+L when m=1.
  - c_F = s+len+m*L otherwise.
  - result <= mac_out at end of c_F; done=1 and busy=0 at c_F+1, then return to IDLE.
- start while busy is ignored; len and bias changes after T are ignored.
- Arithmetic is entirely in the MAC; no rounding or overflow handling in this block. NaN/Inf pass through.
- len = 2^ADDR_W: rd_addr reaches all-ones, with no wrap before the job ends.

Test Plan:
- Reset check: hold rst high 3 cycles, including mid-job -> all outputs 0, state IDLE, no rd_en on the following cycle.
- len=3, w=1.0,2.0,3.0, x=1.0 each, bias=0.5, L=7 -> reduce order 1.5+2.0+3.0, result=32'h40D0_0000 (6.5), done pulse at T+27 only.
- len=0, bias=32'h4040_0000 -> done at T+1, result=3.0, rd_en never asserted, MAC operands stay 0.
- len=1, w=2.0, x=4.0, bias=0 -> no REDUCE, result=32'h4100_0000 (8.0), done at T+2+L+1 = T+10.
- len=20, all w=x=1.0, bias=0 -> per-issue add_a pattern checked (0 for k<7, mac_out after), result=32'h41A0_0000 (20.0), done at T+2+20+49+1 = T+72.
- start pulsed again at T+5 of a running job, plus back-to-back start the cycle after done -> first job unaffected, second job starts with its own latched len/bias and gives a correct result.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: drives one external pipelined float MAC to compute
// result = bias + sum(w[k]*x[k]). MAC_LAT interleaved partial sums are built
// by feeding mac_out back as the addend, then folded serially on the same MAC.
module neuron_mac_seq #(
  parameter int               D_LEN   = 32,
  parameter int               ADDR_W  = 8,
  parameter int               MAC_LAT = 7,
  parameter logic [D_LEN-1:0] ONE     = 32'h3F80_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [D_LEN-1:0]  bias,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [D_LEN-1:0]  w_data,
  input  logic [D_LEN-1:0]  x_data,
  output logic [D_LEN-1:0]  mac_mul_a,
  output logic [D_LEN-1:0]  mac_mul_b,
  output logic [D_LEN-1:0]  mac_add_a,
  input  logic [D_LEN-1:0]  mac_out,
  output logic              busy,
  output logic              done,
  output logic [D_LEN-1:0]  result
);

  localparam int LW = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, RED} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W:0]                 len_q, len_d;
  logic [D_LEN-1:0]                bias_q, bias_d;
  logic [LW-1:0]                   m_q, m_d;           // lanes actually filled
  logic                            rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]               rd_addr_q, rd_addr_d;
  logic                            iss_vld_q, iss_vld_d; // read data valid -> issue now
  logic [ADDR_W-1:0]               iss_k_q, iss_k_d;
  logic [MAC_LAT-1:0]              vld_pipe_q, vld_pipe_d; // tracks main issues through the MAC
  logic [LW-1:0]                   lane_q, lane_d;       // bank slot of the arriving mac_out
  logic [MAC_LAT-1:0][D_LEN-1:0]   bank_q, bank_d;
  logic [LW-1:0]                   red_r_q, red_r_d;     // next reduction step
  logic [LW-1:0]                   tmr_q, tmr_d;         // cycles until that step may issue
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [D_LEN-1:0]                result_q, result_d;

  logic out_vld, out_last, red_issue;

  assign out_vld   = vld_pipe_q[MAC_LAT-1];
  // Main issues are back to back, so the last result is the one with no successor.
  assign out_last  = out_vld && !vld_pipe_q[MAC_LAT-2];
  assign red_issue = (state_q == RED) && (tmr_q == '0) && (red_r_q != m_q);

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

  // MAC operand select: products during the main pass, bank folding during reduction.
  always_comb begin
    mac_mul_a = '0;
    mac_mul_b = '0;
    mac_add_a = '0;
    if (iss_vld_q) begin
      mac_mul_a = x_data;
      mac_mul_b = w_data;
      if (iss_k_q == '0)                mac_add_a = bias_q;
      else if (int'(iss_k_q) < MAC_LAT) mac_add_a = '0;
      else                              mac_add_a = mac_out;
    end else if (red_issue) begin
      mac_mul_a = bank_q[red_r_q];
      mac_mul_b = ONE;
      mac_add_a = (red_r_q == LW'(1)) ? bank_q[0] : mac_out;
    end
  end

  // Next-state: fetch, issue tracking, lane capture and reduction sequencing.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    bias_d     = bias_q;
    m_d        = m_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    iss_vld_d  = rd_en_q;
    iss_k_d    = rd_addr_q;
    vld_pipe_d = {vld_pipe_q[MAC_LAT-2:0], iss_vld_q};
    lane_d     = lane_q;
    bank_d     = bank_q;
    red_r_d    = red_r_q;
    tmr_d      = tmr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d  = len;
          bias_d = bias;
          m_d    = (int'(len) >= MAC_LAT) ? LW'(MAC_LAT) : LW'(len);
          bank_d = '0;
          lane_d = '0;
          if (len == '0) begin
            result_d = bias;
            done_d   = 1'b1;
          end else begin
            state_d   = RUN;
            busy_d    = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
          end
        end
      end
      RUN: begin
        if (rd_en_q) begin
          if ({1'b0, rd_addr_q} == len_q - (ADDR_W+1)'(1)) rd_en_d   = 1'b0;
          else                                            rd_addr_d = rd_addr_q + 1'b1;
        end
        // Later issues overwrite earlier ones in the same slot, leaving each lane's final sum.
        if (out_vld) begin
          bank_d[lane_q] = mac_out;
          lane_d = (lane_q == LW'(MAC_LAT-1)) ? '0 : lane_q + 1'b1;
        end
        if (out_last) begin
          if (m_q == LW'(1)) begin
            result_d = mac_out;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d = RED;
            red_r_d = LW'(1);
            tmr_d   = '0;
          end
        end
      end
      RED: begin
        if (tmr_q == '0) begin
          if (red_r_q == m_q) begin
            result_d = mac_out;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            red_r_d = red_r_q + 1'b1;
            tmr_d   = LW'(MAC_LAT-1);
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      bias_q     <= '0;
      m_q        <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      iss_vld_q  <= 1'b0;
      iss_k_q    <= '0;
      vld_pipe_q <= '0;
      lane_q     <= '0;
      bank_q     <= '0;
      red_r_q    <= '0;
      tmr_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bias_q     <= bias_d;
      m_q        <= m_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      iss_vld_q  <= iss_vld_d;
      iss_k_q    <= iss_k_d;
      vld_pipe_q <= vld_pipe_d;
      lane_q     <= lane_d;
      bank_q     <= bank_d;
      red_r_q    <= red_r_d;
      tmr_q      <= tmr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: memories and a float MAC emulator around the DUT,
// a per-cycle schedule model checked on the falling edge, and directed jobs
// with hand-computed results and done latencies.
module tb_neuron_mac_seq;
  localparam int L = 7;
  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  len = '0;
  logic [31:0] bias = '0;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] w_data = '0, x_data = '0;
  logic [31:0] mac_mul_a, mac_mul_b, mac_add_a, mac_out;
  logic        busy, done;
  logic [31:0] result;

  neuron_mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .rd_en(rd_en), .rd_addr(rd_addr), .w_data(w_data), .x_data(x_data),
    .mac_mul_a(mac_mul_a), .mac_mul_b(mac_mul_b), .mac_add_a(mac_add_a),
    .mac_out(mac_out), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // float32 <-> real for exactly representable normal values
  function automatic real f2r(input logic [31:0] b);
    real m;
    int e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real a;
    int e;
    logic s;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  // Weight/feature memories, one-cycle read latency
  logic [31:0] wmem [0:255];
  logic [31:0] xmem [0:255];
  always @(posedge clk) begin
    w_data <= rd_en ? wmem[rd_addr] : 32'h0;
    x_data <= rd_en ? xmem[rd_addr] : 32'h0;
  end

  // Pipelined MAC emulator, latency L
  logic [31:0] mpipe [0:L-1];
  assign mac_out = mpipe[L-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) mpipe[i] <= 32'h0;
    end else begin
      mpipe[0] <= r2f(f2r(mac_mul_a) * f2r(mac_mul_b) + f2r(mac_add_a));
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  // Job model: schedule times and expected sums from the dot-product definition
  bit          idle = 1'b1;
  int          jT = -100000, jlen = 0, jm = 0, cF = 0, done_at = -1000;
  logic [31:0] jbias = '0, job_res = '0, prev_res = '0;
  real         lane [0:L-1];

  always @(posedge clk) begin
    if (rst) begin
      idle = 1'b1; done_at = -1000; job_res = '0; prev_res = '0; jT = -100000;
    end else if (idle && start) begin
      real sum;
      prev_res = job_res;
      jT = cyc; jlen = int'(len); jbias = bias;
      jm = (jlen < L) ? jlen : L;
      for (int i = 0; i < L; i++) lane[i] = 0.0;
      lane[0] = f2r(bias);
      for (int k = 0; k < jlen; k++) lane[k % L] = lane[k % L] + f2r(wmem[k]) * f2r(xmem[k]);
      sum = lane[0];
      for (int r = 1; r < jm; r++) sum = sum + lane[r];
      if (jlen == 0) begin
        job_res = bias; done_at = cyc + 1;
      end else begin
        cF = (jm == 1) ? (2 + jlen - 1 + L) : (2 + jlen + jm * L);
        job_res = r2f(sum); done_at = jT + cF + 1; idle = 1'b0;
      end
    end else if (!idle && (cyc - jT == cF)) begin
      idle = 1'b1;
    end
    cyc++;
  end

  // Compare process: every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      int t, k, tt;
      logic e_rd;
      logic [31:0] e_a, e_b, e_add;
      t = cyc - jT; e_rd = 1'b0; e_a = '0; e_b = '0; e_add = '0;
      if (!idle) begin
        k = t - 2; tt = t - 2 - jlen;
        if (t >= 1 && t <= jlen) begin
          e_rd = 1'b1;
          chk("rd_addr", 32'(rd_addr), 32'(t - 1));
        end
        if (k >= 0 && k < jlen) begin
          e_a = xmem[k]; e_b = wmem[k];
          e_add = (k == 0) ? jbias : (k < L) ? 32'h0 : mac_out;
        end else if (tt > 0 && tt % L == 0 && tt / L < jm) begin
          e_a = r2f(lane[tt / L]); e_b = ONE;
          e_add = (tt / L == 1) ? r2f(lane[0]) : mac_out;
        end
      end
      chk("rd_en", 32'(rd_en), 32'(e_rd));
      chk("mac_mul_a", mac_mul_a, e_a);
      chk("mac_mul_b", mac_mul_b, e_b);
      chk("mac_add_a", mac_add_a, e_add);
      chk("busy", 32'(busy), 32'(!idle));
      chk("done", 32'(done), 32'(cyc == done_at));
      chk("result", result, (cyc >= done_at) ? job_res : prev_res);
    end
  end

  task automatic fill(input logic [31:0] wv, input logic [31:0] xv);
    for (int i = 0; i < 256; i++) begin wmem[i] = wv; xmem[i] = xv; end
  endtask

  task automatic start_job(input int n, input logic [31:0] b, output int T);
    len = 9'(n); bias = b; start = 1'b1; T = cyc;
    @(posedge clk); #1;
    start = 1'b0; len = '0; bias = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input string nm, input int T, input int exp_off, input logic [31:0] exp_res);
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n == 1000) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no done within 1000 cycles, required at offset %0d", nm, exp_off);
    end else begin
      chk({nm, "_lat"}, 32'(cyc - T), 32'(exp_off));
      chk({nm, "_res"}, result, exp_res);
    end
  endtask

  initial begin
    int T;
    fill(ONE, ONE);
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_result", result, 32'h0);

    // Reset in the middle of a len=20 job
    @(posedge clk); #1;
    start_job(20, 32'h0, T);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_rd_en", 32'(rd_en), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_mul_a", mac_mul_a, 32'h0);
    chk("midrst_result", result, 32'h0);

    // len=3 (6.5) with a stray start at T+5, then back-to-back len=5 (16.0)
    wmem[0] = 32'h3F80_0000; wmem[1] = 32'h4000_0000; wmem[2] = 32'h4040_0000;
    wmem[3] = 32'h4080_0000; wmem[4] = 32'h40A0_0000;
    @(posedge clk); #1;
    start_job(3, 32'h3F00_0000, T);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; len = '0; bias = 32'h4120_0000;
    @(posedge clk); #1 start = 1'b0;
    wait_done("len3", T, 27, 32'h40D0_0000);
    start_job(5, 32'h3F80_0000, T);
    wait_done("len5_b2b", T, 43, 32'h4180_0000);

    // len=0 returns bias immediately
    @(posedge clk); #1;
    start_job(0, 32'h4040_0000, T);
    wait_done("len0", T, 1, 32'h4040_0000);

    // len=1: single product, no reduction
    fill(ONE, ONE);
    wmem[0] = 32'h4000_0000; xmem[0] = 32'h4080_0000;
    @(posedge clk); #1;
    start_job(1, 32'h0, T);
    wait_done("len1", T, 10, 32'h4100_0000);

    // len=20 all ones, and full-range len=256
    fill(ONE, ONE);
    @(posedge clk); #1;
    start_job(20, 32'h0, T);
    wait_done("len20", T, 72, 32'h41A0_0000);
    @(posedge clk); #1;
    start_job(256, 32'h0, T);
    wait_done("len256", T, 308, 32'h4380_0000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
